mem_stage_dmem: RTL and testbench

- MEM-stage data memory unit; sits between the EX/MEM pipeline register and MEM_WB_reg.
- Performs byte, halfword and word loads and stores to a word-organised data RAM. Loads are sign- or zero-extended; misaligned accesses are detected.
- Drives MEM_data into MEM_WB_reg.
- Contains a post-halt dump sequencer that streams the whole RAM to the debug unit over a valid/ready handshake.

---
 rtl/mem_stage_dmem_if.sv | 37 +++
 rtl/mem_stage_dmem.sv | 158 +++++++++++++++
 tb/tb_mem_stage_dmem.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_dmem_if.sv
// Bus bundle between the pipeline (EX/MEM side, debug sink) and the
// MEM-stage data memory: load/store request, load result, and the RAM
// dump stream.
interface mem_stage_dmem_if #(
    parameter int NBITS = 32,
    parameter int ABITS = 8
);
    logic [NBITS-1:0] MEM_addr;
    logic [NBITS-1:0] MEM_wdata;
    logic             MEM_memread;
    logic             MEM_memwrite;
    logic [1:0]       MEM_size;
    logic             MEM_unsigned;
    logic [NBITS-1:0] MEM_data;
    logic             o_misalign;
    logic             i_halt;
    logic             i_dump_start;
    logic             i_dump_ready;
    logic             o_dump_valid;
    logic [NBITS-1:0] o_dump_data;
    logic [ABITS-1:0] o_dump_addr;
    logic             o_dump_done;

    modport master (
        output MEM_addr, MEM_wdata, MEM_memread, MEM_memwrite, MEM_size,
               MEM_unsigned, i_halt, i_dump_start, i_dump_ready,
        input  MEM_data, o_misalign, o_dump_valid, o_dump_data,
               o_dump_addr, o_dump_done
    );

    modport slave (
        input  MEM_addr, MEM_wdata, MEM_memread, MEM_memwrite, MEM_size,
               MEM_unsigned, i_halt, i_dump_start, i_dump_ready,
        output MEM_data, o_misalign, o_dump_valid, o_dump_data,
               o_dump_addr, o_dump_done
    );
endinterface

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: byte/half/word loads (combinational, sign or zero
// extended) and byte-enabled stores into a word-organised RAM, plus a
// post-halt sequencer that streams the whole RAM out over valid/ready.
//
// state  | meaning
// IDLE   | normal load/store operation, waiting for a dump request
// DUMP   | presenting RAM[cnt] to the debug sink, stores blocked
// DONE   | one-cycle completion pulse, counter cleared
module mem_stage_dmem #(
    parameter int NBITS = 32,
    parameter int ABITS = 8,
    parameter int DEPTH = 2 ** ABITS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mem_stage_dmem_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] mem [DEPTH];

    logic [ABITS-1:0] widx;
    logic [1:0]       lane;
    logic             access;
    logic             misalign_raw;
    logic             misalign;
    logic [NBITS-1:0] rword;
    logic [NBITS-1:0] shifted;
    logic [NBITS-1:0] load_data;
    logic [3:0]       be;
    logic [NBITS-1:0] wd;
    logic             we;
    logic             dump_valid;
    logic             dump_done;

    // Upper address bits wrap around; kept only so nothing dangles.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.MEM_addr[NBITS-1:ABITS+2];

    assign widx   = bus.MEM_addr[ABITS+1:2];
    assign lane   = bus.MEM_addr[1:0];
    assign access = bus.MEM_memread | bus.MEM_memwrite;

    // Alignment check; the reserved size code behaves like a word access.
    always_comb begin
        misalign_raw = 1'b0;
        case (bus.MEM_size)
            2'b00:   misalign_raw = 1'b0;
            2'b01:   misalign_raw = lane[0];
            default: misalign_raw = (lane != 2'b00);
        endcase
    end

    assign misalign       = access & misalign_raw;
    assign bus.o_misalign = misalign;

    assign rword   = mem[widx];
    assign shifted = rword >> {lane, 3'b000};

    // Load path: pick the lane(s), extend, and squash when not a valid load.
    always_comb begin
        load_data = '0;
        case (bus.MEM_size)
            2'b00:   load_data = {{(NBITS-8){~bus.MEM_unsigned & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{(NBITS-16){~bus.MEM_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_data = rword;
        endcase
        if (i_rst || !bus.MEM_memread || misalign) begin
            load_data = '0;
        end
    end

    assign bus.MEM_data = load_data;

    // Store lane enables and lane-replicated write data.
    always_comb begin
        be = 4'b0000;
        wd = bus.MEM_wdata;
        case (bus.MEM_size)
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{bus.MEM_wdata[7:0]}};
            end
            2'b01: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{bus.MEM_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = bus.MEM_wdata;
            end
        endcase
    end

    assign we = bus.MEM_memwrite & ~misalign & (state_q == S_IDLE);

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][b*8 +: 8] <= wd[b*8 +: 8];
                end
            end
        end
    end

    // Dump sequencer state and word counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Dump sequencer next state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_dump_start && bus.i_halt) begin
                    state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                dump_valid = 1'b1;
                if (bus.i_dump_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ABITS'(DEPTH - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                dump_done = 1'b1;
                cnt_d     = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.o_dump_valid = dump_valid;
    assign bus.o_dump_done  = dump_done;
    assign bus.o_dump_data  = mem[cnt_q];
    assign bus.o_dump_addr  = cnt_q;
endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed bench for the MEM-stage data memory and its dump sequencer.
module tb_mem_stage_dmem;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_stage_dmem_if #(.NBITS(32), .ABITS(8)) bus ();

    mem_stage_dmem #(.NBITS(32), .ABITS(8), .DEPTH(256)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.MEM_addr     = '0;
        bus.MEM_wdata    = '0;
        bus.MEM_memread  = 1'b0;
        bus.MEM_memwrite = 1'b0;
        bus.MEM_size     = 2'b11;
        bus.MEM_unsigned = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        bus.MEM_addr     = addr;
        bus.MEM_wdata    = data;
        bus.MEM_size     = size;
        bus.MEM_memread  = 1'b0;
        bus.MEM_memwrite = 1'b1;
        tick();
        bus.MEM_memwrite = 1'b0;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        bus.MEM_addr     = addr;
        bus.MEM_size     = size;
        bus.MEM_unsigned = uns;
        bus.MEM_memwrite = 1'b0;
        bus.MEM_memread  = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        bus.i_halt       = 1'b0;
        bus.i_dump_start = 1'b0;
        bus.i_dump_ready = 1'b0;
        bus.MEM_memread  = 1'b1;
        bus.MEM_addr     = 32'h10;
        #3;
        checks++;
        if (bus.o_dump_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_dump_valid);
        end
        checks++;
        if (bus.o_dump_done !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%b exp=0", bus.o_dump_done);
        end
        checks++;
        if (bus.MEM_data !== 32'h0) begin
            failures++; $display("FAIL reset_memdata got=%h exp=00000000", bus.MEM_data);
        end
        tick();
        tick();
        rst = 1'b0;
        idle_bus();
        tick();
    endtask

    task automatic test_word_byte();
        do_store(32'h10, 32'hDEADBEEF, 2'b11);
        set_load(32'h10, 2'b11, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL word_load got=%h exp=deadbeef", bus.MEM_data);
        end
        set_load(32'h13, 2'b00, 1'b1);
        checks++;
        if (bus.MEM_data !== 32'h000000DE) begin
            failures++; $display("FAIL byte_unsigned got=%h exp=000000de", bus.MEM_data);
        end
        set_load(32'h11, 2'b00, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'hFFFFFFBE) begin
            failures++; $display("FAIL byte_signed got=%h exp=ffffffbe", bus.MEM_data);
        end
        bus.MEM_memread = 1'b0;
        #1;
        checks++;
        if (bus.MEM_data !== 32'h0) begin
            failures++; $display("FAIL no_read_zero got=%h exp=00000000", bus.MEM_data);
        end
    endtask

    task automatic test_partial_store();
        do_store(32'h12, 32'hAAAA1234, 2'b01);
        set_load(32'h10, 2'b11, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'h1234BEEF) begin
            failures++; $display("FAIL half_store got=%h exp=1234beef", bus.MEM_data);
        end
        do_store(32'h10, 32'hAAAAAA55, 2'b00);
        set_load(32'h10, 2'b11, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'h1234BE55) begin
            failures++; $display("FAIL byte_store got=%h exp=1234be55", bus.MEM_data);
        end
        set_load(32'h12, 2'b01, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'h00001234) begin
            failures++; $display("FAIL half_signed_hi got=%h exp=00001234", bus.MEM_data);
        end
        set_load(32'h10, 2'b01, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'hFFFFBE55) begin
            failures++; $display("FAIL half_signed_lo got=%h exp=ffffbe55", bus.MEM_data);
        end
        set_load(32'h10, 2'b01, 1'b1);
        checks++;
        if (bus.MEM_data !== 32'h0000BE55) begin
            failures++; $display("FAIL half_unsigned_lo got=%h exp=0000be55", bus.MEM_data);
        end
        set_load(32'h10, 2'b11, 1'b1);
        checks++;
        if (bus.MEM_data !== 32'h1234BE55) begin
            failures++; $display("FAIL word_ignores_unsigned got=%h exp=1234be55", bus.MEM_data);
        end
        bus.MEM_memread = 1'b0;
    endtask

    task automatic test_misalign();
        bus.MEM_addr     = 32'h11;
        bus.MEM_wdata    = 32'hFFFFFFFF;
        bus.MEM_size     = 2'b11;
        bus.MEM_memread  = 1'b0;
        bus.MEM_memwrite = 1'b1;
        #1;
        checks++;
        if (bus.o_misalign !== 1'b1) begin
            failures++; $display("FAIL misalign_word_store got=%b exp=1", bus.o_misalign);
        end
        tick();
        bus.MEM_memwrite = 1'b0;
        set_load(32'h10, 2'b11, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'h1234BE55) begin
            failures++; $display("FAIL misalign_store_suppressed got=%h exp=1234be55", bus.MEM_data);
        end
        set_load(32'h13, 2'b01, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'h0 || bus.o_misalign !== 1'b1) begin
            failures++; $display("FAIL misalign_half_load data=%h mis=%b exp data=00000000 mis=1", bus.MEM_data, bus.o_misalign);
        end
        bus.MEM_memread = 1'b0;
        #1;
        checks++;
        if (bus.o_misalign !== 1'b0) begin
            failures++; $display("FAIL misalign_no_access got=%b exp=0", bus.o_misalign);
        end
        set_load(32'h12, 2'b10, 1'b0);
        checks++;
        if (bus.o_misalign !== 1'b1 || bus.MEM_data !== 32'h0) begin
            failures++; $display("FAIL misalign_reserved mis=%b data=%h exp mis=1 data=00000000", bus.o_misalign, bus.MEM_data);
        end
        set_load(32'h10, 2'b10, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'h1234BE55 || bus.o_misalign !== 1'b0) begin
            failures++; $display("FAIL reserved_as_word data=%h mis=%b exp data=1234be55 mis=0", bus.MEM_data, bus.o_misalign);
        end
        set_load(32'h410, 2'b11, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'h1234BE55) begin
            failures++; $display("FAIL addr_alias got=%h exp=1234be55", bus.MEM_data);
        end
        bus.MEM_memread = 1'b0;
    endtask

    task automatic test_read_write_same();
        do_store(32'h20, 32'h1, 2'b11);
        bus.MEM_addr     = 32'h20;
        bus.MEM_wdata    = 32'h2;
        bus.MEM_size     = 2'b11;
        bus.MEM_memread  = 1'b1;
        bus.MEM_memwrite = 1'b1;
        #1;
        checks++;
        if (bus.MEM_data !== 32'h1) begin
            failures++; $display("FAIL rw_old got=%h exp=00000001", bus.MEM_data);
        end
        tick();
        bus.MEM_memwrite = 1'b0;
        #1;
        checks++;
        if (bus.MEM_data !== 32'h2) begin
            failures++; $display("FAIL rw_new got=%h exp=00000002", bus.MEM_data);
        end
        bus.MEM_memread = 1'b0;
    endtask

    task automatic fill_ram();
        for (int k = 0; k < 256; k++) begin
            do_store(32'(k * 4), 32'(k), 2'b11);
        end
    endtask

    task automatic test_start_without_halt();
        bus.i_halt       = 1'b0;
        bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.o_dump_valid !== 1'b0) begin
                failures++; $display("FAIL start_no_halt cycle=%0d valid=%b exp=0", c, bus.o_dump_valid);
            end
            tick();
        end
    endtask

    task automatic test_dump();
        int          exp_idx;
        int          cycles;
        logic        stalled;
        logic [31:0] hold_data;
        logic [7:0]  hold_addr;
        exp_idx   = 0;
        cycles    = 0;
        stalled   = 1'b0;
        hold_data = '0;
        hold_addr = '0;
        bus.i_halt       = 1'b1;
        bus.i_dump_ready = 1'b0;
        bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        bus.MEM_addr     = 32'h0;
        bus.MEM_wdata    = 32'hFFFFFFFF;
        bus.MEM_size     = 2'b11;
        bus.MEM_memwrite = 1'b1;
        while (exp_idx < 256 && cycles < 2000) begin
            bus.i_dump_ready = cycles[0];
            if (exp_idx == 50) bus.i_halt = 1'b0;
            #1;
            checks++;
            if (bus.o_dump_valid !== 1'b1) begin
                failures++; $display("FAIL dump_valid idx=%0d got=%b exp=1", exp_idx, bus.o_dump_valid);
            end
            if (stalled) begin
                checks++;
                if (bus.o_dump_data !== hold_data || bus.o_dump_addr !== hold_addr) begin
                    failures++; $display("FAIL dump_stall_hold addr=%0d data=%h exp addr=%0d data=%h", bus.o_dump_addr, bus.o_dump_data, hold_addr, hold_data);
                end
            end
            if (bus.i_dump_ready) begin
                checks++;
                if (bus.o_dump_addr !== 8'(exp_idx) || bus.o_dump_data !== 32'(exp_idx)) begin
                    failures++; $display("FAIL dump_word addr=%0d data=%h exp addr=%0d data=%h", bus.o_dump_addr, bus.o_dump_data, exp_idx, 32'(exp_idx));
                end
                exp_idx++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                hold_data = bus.o_dump_data;
                hold_addr = bus.o_dump_addr;
            end
            tick();
            cycles++;
        end
        if (exp_idx < 256) begin
            checks++;
            failures++;
            $display("FAIL dump_timeout accepted=%0d exp=256", exp_idx);
        end
        bus.i_dump_ready = 1'b0;
        #1;
        checks++;
        if (bus.o_dump_done !== 1'b1 || bus.o_dump_valid !== 1'b0) begin
            failures++; $display("FAIL dump_done_pulse done=%b valid=%b exp done=1 valid=0", bus.o_dump_done, bus.o_dump_valid);
        end
        tick();
        bus.MEM_memwrite = 1'b0;
        checks++;
        if (bus.o_dump_done !== 1'b0 || bus.o_dump_valid !== 1'b0) begin
            failures++; $display("FAIL dump_done_once done=%b valid=%b exp done=0 valid=0", bus.o_dump_done, bus.o_dump_valid);
        end
        set_load(32'h0, 2'b11, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'h0) begin
            failures++; $display("FAIL dump_store_blocked got=%h exp=00000000", bus.MEM_data);
        end
        set_load(32'h3FC, 2'b11, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'hFF) begin
            failures++; $display("FAIL ram_last_word got=%h exp=000000ff", bus.MEM_data);
        end
        bus.MEM_memread = 1'b0;
    endtask

    task automatic test_reset_mid_dump();
        int cycles;
        cycles = 0;
        bus.i_halt       = 1'b1;
        bus.i_dump_ready = 1'b1;
        bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        while (bus.o_dump_addr !== 8'd100 && cycles < 400) begin
            tick();
            cycles++;
        end
        checks++;
        if (bus.o_dump_addr !== 8'd100 || bus.o_dump_valid !== 1'b1) begin
            failures++; $display("FAIL reach_word100 addr=%0d valid=%b exp addr=100 valid=1", bus.o_dump_addr, bus.o_dump_valid);
        end
        bus.MEM_addr    = 32'h4;
        bus.MEM_size    = 2'b11;
        bus.MEM_memread = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.o_dump_valid !== 1'b0 || bus.o_dump_addr !== 8'd0) begin
            failures++; $display("FAIL rst_mid_dump valid=%b addr=%0d exp valid=0 addr=0", bus.o_dump_valid, bus.o_dump_addr);
        end
        checks++;
        if (bus.MEM_data !== 32'h0) begin
            failures++; $display("FAIL rst_forces_memdata got=%h exp=00000000", bus.MEM_data);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.MEM_data !== 32'h1 || bus.o_dump_valid !== 1'b0) begin
            failures++; $display("FAIL after_rst data=%h valid=%b exp data=00000001 valid=0", bus.MEM_data, bus.o_dump_valid);
        end
        bus.MEM_memread  = 1'b0;
        bus.i_dump_ready = 1'b0;
        bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        checks++;
        if (bus.o_dump_valid !== 1'b1 || bus.o_dump_addr !== 8'd0 || bus.o_dump_data !== 32'h0) begin
            failures++; $display("FAIL redump_start valid=%b addr=%0d data=%h exp valid=1 addr=0 data=00000000", bus.o_dump_valid, bus.o_dump_addr, bus.o_dump_data);
        end
        bus.i_dump_ready = 1'b1;
        tick();
        checks++;
        if (bus.o_dump_addr !== 8'd1 || bus.o_dump_data !== 32'h1) begin
            failures++; $display("FAIL redump_second addr=%0d data=%h exp addr=1 data=00000001", bus.o_dump_addr, bus.o_dump_data);
        end
        bus.i_dump_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_load(32'h190, 2'b11, 1'b0);
        checks++;
        if (bus.MEM_data !== 32'd100) begin
            failures++; $display("FAIL ram_intact got=%h exp=00000064", bus.MEM_data);
        end
        bus.MEM_memread = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_word_byte();
        test_partial_store();
        test_misalign();
        test_read_write_same();
        fill_ram();
        test_start_without_halt();
        test_dump();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
